// File: rtl/pipeline1_pkg.sv
// Shared processor constants: widths, opcode encodings and fetch-stage state encodings.
package pipeline1_pkg;

  localparam int unsigned PC_W     = 16;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_EOF = 6'h3F;

  typedef enum logic [1:0] {
    IfFill,
    IfRun,
    IfHalt
  } if_state_e;

endpackage

// File: rtl/pipeline1.sv
// Instruction-fetch stage: PC, synchronous imem addressing, redirect squash, stall hold and
// EOF halt.
module pipeline1
  import pipeline1_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = PC_W,
  parameter int unsigned         INSTR_WIDTH  = INSTR_W,
  parameter int unsigned         OPCODE_WIDTH = OPCODE_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   halted
);

  localparam logic [INSTR_WIDTH-1:0]  NopInstr = INSTR_WIDTH'(OP_NOP);
  localparam logic [OPCODE_WIDTH-1:0] EofOp    = OPCODE_WIDTH'(OP_EOF);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   fv_q, fv_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
  if_state_e              state_q, state_d;
  logic                   is_eof;

  // Under stall the in-flight address is re-read so imem_data stays aligned with fetch_pc.
  assign imem_addr = stall ? fetch_pc_q : pc_q;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign halted    = (state_q == IfHalt);
  assign is_eof    = (imem_data[OPCODE_WIDTH-1:0] == EofOp);

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    fv_d       = fv_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    state_d    = state_q;
    if (branch_en) begin
      pc_d     = branch_pc;
      fv_d     = 1'b0;
      instr_d  = NopInstr;
      pc_out_d = '0;
      state_d  = IfFill;
    end else if (!stall) begin
      unique case (state_q)
        IfHalt: begin
          fv_d     = 1'b0;
          instr_d  = NopInstr;
          pc_out_d = '0;
        end
        IfFill, IfRun: begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_WIDTH'(1);
          fv_d       = 1'b1;
          if (fv_q) begin
            instr_d  = imem_data;
            pc_out_d = fetch_pc_q + PC_WIDTH'(1);
          end else begin
            instr_d  = NopInstr;
            pc_out_d = '0;
          end
          if (state_q == IfFill) begin
            state_d = IfRun;
          end else if (fv_q && is_eof) begin
            state_d = IfHalt;
          end
        end
        default: state_d = IfFill;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      fv_q       <= 1'b0;
      instr_q    <= NopInstr;
      pc_out_q   <= '0;
      state_q    <= IfFill;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      fv_q       <= fv_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_pipeline1.sv
// Directed bench for pipeline1: sequential fetch, stall, redirect, EOF halt, wrap and async reset.
module tb_pipeline1;
  import pipeline1_pkg::*;

  logic        clk_in = 1'b0;
  logic        RST;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_pc;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [15:0] pc_out;
  logic        halted;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] EofWord = 32'h0000_003F;
  localparam logic [31:0] Nop     = 32'h0;

  pipeline1 dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .stall     (stall),
    .branch_en (branch_en),
    .branch_pc (branch_pc),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .instr     (instr),
    .pc_out    (pc_out),
    .halted    (halted)
  );

  always #5 clk_in = ~clk_in;

  // Word k holds k+100, except word 5 which is EOF.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'd5) return EofWord;
    return 32'(a) + 32'd100;
  endfunction

  always @(posedge clk_in) imem_data <= mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] i, input logic [15:0] p,
                            input logic h);
    check_eq({tag, ".instr"}, instr, i);
    check_eq({tag, ".pc_out"}, 32'(pc_out), 32'(p));
    check_eq({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic redirect(input logic [15:0] target, input logic with_stall);
    branch_en = 1'b1;
    branch_pc = target;
    stall     = with_stall;
    tick();
    branch_en = 1'b0;
    stall     = 1'b0;
  endtask

  initial begin
    RST       = 1'b0;
    stall     = 1'b0;
    branch_en = 1'b0;
    branch_pc = '0;
    #3;
    expect_out("rst", Nop, 16'd0, 1'b0);
    check_eq("rst.imem_addr", 32'(imem_addr), 32'd0);
    #5 RST = 1'b1;

    // Two-cycle fill, then sequential words.
    tick(); expect_out("e0", Nop, 16'd0, 1'b0);
    tick(); expect_out("e1", 32'd100, 16'd1, 1'b0);
    tick(); expect_out("e2", 32'd101, 16'd2, 1'b0);
    tick(); expect_out("e3", 32'd102, 16'd3, 1'b0);

    stall = 1'b1;
    #1 check_eq("stall.addr0", 32'(imem_addr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 32'd102, 16'd3, 1'b0);
      check_eq("stall.addr", 32'(imem_addr), 32'd3);
    end
    stall = 1'b0;
    tick(); expect_out("post_stall", 32'd103, 16'd4, 1'b0);

    // Redirect coincident with stall.
    redirect(16'd500, 1'b1); expect_out("br500.b0", Nop, 16'd0, 1'b0);
    tick(); expect_out("br500.b1", Nop, 16'd0, 1'b0);
    tick(); expect_out("br500.t", 32'd600, 16'd501, 1'b0);
    tick(); expect_out("br500.t1", 32'd601, 16'd502, 1'b0);

    // Run into EOF at word 5.
    redirect(16'd3, 1'b0); expect_out("br3.b0", Nop, 16'd0, 1'b0);
    tick(); expect_out("br3.b1", Nop, 16'd0, 1'b0);
    tick(); expect_out("w3", 32'd103, 16'd4, 1'b0);
    tick(); expect_out("w4", 32'd104, 16'd5, 1'b0);
    tick(); expect_out("eof", EofWord, 16'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halt.instr", instr, Nop);
      check_eq("halt.halted", 32'(halted), 32'd1);
      check_eq("halt.addr", 32'(imem_addr), 32'd7);
    end
    stall = 1'b1;
    tick();
    check_eq("halt_stall.instr", instr, Nop);
    check_eq("halt_stall.halted", 32'(halted), 32'd1);
    stall = 1'b0;

    // Wrong-path EOF recovery.
    redirect(16'd20, 1'b0); expect_out("br20.b0", Nop, 16'd0, 1'b0);
    tick(); expect_out("br20.b1", Nop, 16'd0, 1'b0);
    tick(); expect_out("br20.t", 32'd120, 16'd21, 1'b0);

    // PC wrap.
    redirect(16'hFFFF, 1'b0); expect_out("wrap.b0", Nop, 16'd0, 1'b0);
    tick(); expect_out("wrap.b1", Nop, 16'd0, 1'b0);
    tick(); expect_out("wrap.max", 32'd65635, 16'd0, 1'b0);
    tick(); expect_out("wrap.zero", 32'd100, 16'd1, 1'b0);

    // Asynchronous reset between edges.
    #2 RST = 1'b0;
    #1;
    expect_out("async_rst", Nop, 16'd0, 1'b0);
    check_eq("async_rst.addr", 32'(imem_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
